axi4_lite_read_arbiter: RTL

Round-robin arbiter that shares the single AXI4-Lite read path (AR/R channels) into the interconnect between `N_MASTERS` requesters, e.g. CPU instruction fetch (master 0) and data load (master 1). It carries one outstanding read at a time. It decodes each granted address against the address-map package (`axi4_lite_addr_map_package`: `SLAVE_NUM`, `SLAVE_BASE_ADDR`, `SLAVE_ADDR_MASK`). Unmapped reads get a local DECERR and are never forwarded downstream.

---
 rtl/axi4_lite_read_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/axi4_lite_read_arbiter.sv
// rtl/axi4_lite_read_arbiter.sv - round-robin AXI4-Lite read-path arbiter with local DECERR for unmapped reads
package axi4_lite_addr_map_package;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int SLAVE_NUM  = 3;
  localparam logic [ADDR_WIDTH-1:0] SLAVE_BASE_ADDR [SLAVE_NUM] =
    '{32'h0000_0000, 32'h0000_0100, 32'h0000_1000};
  localparam logic [ADDR_WIDTH-1:0] SLAVE_ADDR_MASK [SLAVE_NUM] =
    '{32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FFFF};
endpackage

module axi4_lite_read_arbiter #(
  parameter int N_MASTERS  = 2,
  parameter int ADDR_WIDTH = axi4_lite_addr_map_package::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi4_lite_addr_map_package::DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] s_araddr,
  input  logic [N_MASTERS-1:0]          s_arvalid,
  output logic [N_MASTERS-1:0]          s_arready,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [1:0]                    s_rresp,
  output logic [N_MASTERS-1:0]          s_rvalid,
  input  logic [N_MASTERS-1:0]          s_rready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rvalid,
  output logic                          m_rready
);

  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic                  win_found;
  logic [GW-1:0]         win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  int                    rr_idx;

  function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
    addr_hit = 1'b0;
    for (int k = 0; k < axi4_lite_addr_map_package::SLAVE_NUM; k++) begin
      if ((a & ADDR_WIDTH'(axi4_lite_addr_map_package::SLAVE_ADDR_MASK[k])) ==
          ADDR_WIDTH'(axi4_lite_addr_map_package::SLAVE_BASE_ADDR[k]))
        addr_hit = 1'b1;
    end
  endfunction

  // Search begins one past the last served master so contenders alternate.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      rr_idx = (int'(last_grant_q) + i) % N_MASTERS;
      if (!win_found && s_arvalid[rr_idx]) begin
        win_found = 1'b1;
        win_idx   = GW'(rr_idx);
      end
    end
    win_addr = s_araddr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    s_arready    = '0;
    s_rvalid     = '0;
    s_rdata      = '0;
    s_rresp      = 2'b00;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    m_araddr     = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          s_arready[win_idx] = 1'b1;
          addr_d             = win_addr;
          grant_d            = win_idx;
          state_d            = addr_hit(win_addr) ? ST_ADDR : ST_ERR;
        end
      end
      ST_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        m_rready          = s_rready[grant_q];
        s_rvalid[grant_q] = m_rvalid;
        s_rdata           = m_rdata;
        s_rresp           = m_rresp;
        if (m_rvalid && s_rready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      ST_ERR: begin
        // Unmapped address: answer locally with DECERR, never touch downstream.
        s_rvalid[grant_q] = 1'b1;
        s_rresp           = 2'b11;
        if (s_rready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_MASTERS - 1);
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
    end
  end

endmodule
